// File: rtl/cfg_loader.sv
// cfg_loader: Wishbone initiator that turns one-shot store/load commands into
// the configuration slave's register sequence.
//   store: ADDR, DATA_0..DATA_n-1, CTRL=1
//   load : ADDR, CTRL=2, LOAD_WAIT idle cycles, read DATA_0..DATA_n-1
//
// Ports
//   clk_i, rst_n_i               clock, async active-low reset
//   cmd_valid_i/cmd_ready_o      command handshake (ready only in IDLE)
//   cmd_op_i                     0=store, 1=load
//   cmd_addr_i                   value written to slave ADDR register
//   cmd_nwords_i                 1..4 words (0 -> 1, 5..7 -> 4)
//   cmd_data_i                   store data, word k = bits [32k+31:32k]
//   rsp_valid_o/rsp_ready_i      response handshake, held until accepted
//   rsp_data_o, rsp_err_o        load data (unread words zero), timeout flag
//   wbm_*                        wishbone master port
//
// Optional feature: define CFG_LOADER_TIMEOUT_EN to abort a bus access whose
// stb has been high ACK_TIMEOUT cycles without ack. Undefined: wait forever,
// rsp_err_o tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | ready for a command
// WR_ADDR | write memory address to slave ADDR (+0x00)
// WR_DATA | write DATA_k (+0x08+4k), k = 0..n-1
// WR_CTRL | write CTRL (+0x04): 1 = store, 2 = load
// LD_WAIT | LOAD_WAIT idle cycles while the slave fetches
// RD_DATA | read DATA_k into response word k
// RSP     | response valid until rsp_ready_i
//
// Every bus state has a REQ phase (cyc=stb=1 until ack) followed by a one
// cycle GAP (gap_q=1); the slave acks every stb cycle, so the gap keeps a
// stale ack from completing the next access.

module cfg_loader #(
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
  parameter int          LOAD_WAIT          = 4,
  parameter int          ACK_TIMEOUT        = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic         cmd_op_i,
  input  logic [31:0]  cmd_addr_i,
  input  logic [2:0]   cmd_nwords_i,
  input  logic [127:0] cmd_data_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_CTRL, LD_WAIT, RD_DATA, RSP
  } state_t;

  localparam int TMR_MAX = (LOAD_WAIT > ACK_TIMEOUT) ? LOAD_WAIT : ACK_TIMEOUT;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(LOAD_WAIT - 1);
`ifdef CFG_LOADER_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LOAD  = TW'(ACK_TIMEOUT - 1);
`endif

  state_t         state_q, state_d;
  logic           gap_q, gap_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           rdy_q, rdy_d;
  logic           op_q, op_d;
  logic [31:0]    addr_q, addr_d;
  logic [1:0]     nw_q, nw_d;      // clamped word count minus one
  logic [127:0]   data_q, data_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
`ifdef CFG_LOADER_TIMEOUT_EN
  logic           err_q, err_d;
`endif

  logic [1:0]     nw_clamp;
  logic           req;

  always_comb begin
    if (cmd_nwords_i == 3'd0)     nw_clamp = 2'd0;
    else if (cmd_nwords_i > 3'd4) nw_clamp = 2'd3;
    else                          nw_clamp = 2'(cmd_nwords_i - 3'd1);
  end

  assign req = !gap_q && (state_q == WR_ADDR || state_q == WR_DATA ||
                          state_q == WR_CTRL || state_q == RD_DATA);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    wcnt_d     = wcnt_q;
    tmr_d      = tmr_q;
    op_d       = op_q;
    addr_d     = addr_q;
    nw_d       = nw_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
`ifdef CFG_LOADER_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && rdy_q) begin
          op_d       = cmd_op_i;
          addr_d     = cmd_addr_i;
          nw_d       = nw_clamp;
          data_d     = cmd_data_i;
          rsp_data_d = '0;
          gap_d      = 1'b0;
          wcnt_d     = 2'd0;
          state_d    = WR_ADDR;
`ifdef CFG_LOADER_TIMEOUT_EN
          err_d      = 1'b0;
          tmr_d      = TMO_LOAD;
`endif
        end
      end
      LD_WAIT: begin
        if (tmr_q == '0) begin
          state_d = RD_DATA;
          wcnt_d  = 2'd0;
`ifdef CFG_LOADER_TIMEOUT_EN
          tmr_d   = TMO_LOAD;
`endif
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: begin
        if (!gap_q) begin
          if (wbm_ack_i) begin
            gap_d = 1'b1;
            if (state_q == RD_DATA) rsp_data_d[32*wcnt_q +: 32] = wbm_dat_i;
`ifdef CFG_LOADER_TIMEOUT_EN
            tmr_d = TMO_LOAD;
          end else if (tmr_q == '0) begin
            // abort: drop the bus and report an error with no data
            state_d    = RSP;
            gap_d      = 1'b0;
            rsp_data_d = '0;
            err_d      = 1'b1;
          end else begin
            tmr_d = tmr_q - 1'b1;
`endif
          end
        end else begin
          gap_d = 1'b0;
          case (state_q)
            WR_ADDR: state_d = op_q ? WR_CTRL : WR_DATA;
            WR_DATA: begin
              if (wcnt_q == nw_q) begin
                state_d = WR_CTRL;
                wcnt_d  = 2'd0;
              end else begin
                wcnt_d = wcnt_q + 2'd1;
              end
            end
            WR_CTRL: begin
              if (op_q) begin
                state_d = LD_WAIT;
                tmr_d   = WAIT_LOAD;
              end else begin
                state_d = RSP;
              end
            end
            RD_DATA: begin
              if (wcnt_q == nw_q) state_d = RSP;
              else                wcnt_d  = wcnt_q + 2'd1;
            end
            default: ;
          endcase
        end
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      gap_q      <= 1'b0;
      wcnt_q     <= 2'd0;
      tmr_q      <= '0;
      rdy_q      <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      nw_q       <= 2'd0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wcnt_q     <= wcnt_d;
      tmr_q      <= tmr_d;
      rdy_q      <= rdy_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      nw_q       <= nw_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef CFG_LOADER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign cmd_ready_o = rdy_q;
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_data_o  = rsp_data_q;
  assign wbm_cyc_o   = req;
  assign wbm_stb_o   = req;
  assign wbm_we_o    = req && (state_q != RD_DATA);
  assign wbm_sel_o   = req ? 4'hF : 4'h0;

  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    if (req) begin
      case (state_q)
        WR_ADDR: begin
          wbm_adr_o = WISHBONE_BASE_ADDR;
          wbm_dat_o = addr_q;
        end
        WR_DATA: begin
          wbm_adr_o = WISHBONE_BASE_ADDR + 32'h8 + {28'h0, wcnt_q, 2'b00};
          wbm_dat_o = data_q[32*wcnt_q +: 32];
        end
        WR_CTRL: begin
          wbm_adr_o = WISHBONE_BASE_ADDR + 32'h4;
          wbm_dat_o = op_q ? 32'd2 : 32'd1;
        end
        RD_DATA: wbm_adr_o = WISHBONE_BASE_ADDR + 32'h8 + {28'h0, wcnt_q, 2'b00};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
`timescale 1ns/1ps
module tb_cfg_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int LW  = 4;
  localparam int TMO = 16;

  logic         clk_i, rst_n_i;
  logic         cmd_valid_i, cmd_ready_o, cmd_op_i;
  logic [31:0]  cmd_addr_i;
  logic [2:0]   cmd_nwords_i;
  logic [127:0] cmd_data_i;
  logic         rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [127:0] rsp_data_o;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i;

  cfg_loader #(.WISHBONE_BASE_ADDR(BASE), .LOAD_WAIT(LW), .ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_nwords_i(cmd_nwords_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // slave: ack after ack_dly stb-high cycles, read data from rd_mem
  int          ack_dly   = 1;
  bit          never_ack = 1'b0;
  int          scnt      = 0;
  logic [31:0] rd_mem [4];
  logic [31:0] off;
  logic [64:0] bus_log [$];

  always_comb begin
    wbm_dat_i = 32'h0;
    off       = wbm_adr_o - BASE - 32'h8;
    if (wbm_adr_o >= BASE + 32'h8 && wbm_adr_o <= BASE + 32'h14) wbm_dat_i = rd_mem[off[3:2]];
  end

  always @(posedge clk_i) begin
    if (wbm_stb_o && wbm_ack_i)
      bus_log.push_back({wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : wbm_dat_i});
    if (!wbm_stb_o || never_ack) begin
      scnt      <= 0;
      wbm_ack_i <= 1'b0;
    end else begin
      scnt      <= scnt + 1;
      wbm_ack_i <= (scnt + 1 >= ack_dly);
    end
  end

  // bus monitor: stb run lengths, idle before a first read, gap rule
  int stb_run = 0, last_run = 0, idle_run = 0, first_rd_idle = 0, gap_err = 0;
  bit prev_acc = 1'b0;
  always @(posedge clk_i) begin
    if (prev_acc && wbm_stb_o) gap_err <= gap_err + 1;
    prev_acc <= wbm_stb_o && wbm_ack_i;
    if (wbm_stb_o) begin
      if (stb_run == 0 && !wbm_we_o && wbm_adr_o == BASE + 32'h8) first_rd_idle <= idle_run;
      stb_run  <= stb_run + 1;
      idle_run <= 0;
    end else begin
      if (stb_run > 0) last_run <= stb_run;
      stb_run  <= 0;
      idle_run <= idle_run + 1;
    end
  end

  function automatic int clampn(input logic [2:0] n);
    if (n == 3'd0) return 1;
    if (n > 3'd4)  return 4;
    return int'(n);
  endfunction

  task automatic run_cmd(input string name, input bit op, input logic [31:0] addr,
                         input logic [2:0] nw, input logic [127:0] data,
                         input int dly, input int hold);
    int          n;
    int          exp_lat;
    int          lat;
    logic [64:0] exp_q [$];
    logic [127:0] exp_data;
    n        = clampn(nw);
    exp_data = '0;
    exp_q.push_back({1'b1, BASE, addr});
    if (!op) begin
      for (int k = 0; k < n; k++) exp_q.push_back({1'b1, BASE + 32'h8 + 32'(4*k), data[32*k +: 32]});
      exp_q.push_back({1'b1, BASE + 32'h4, 32'd1});
      exp_lat = (n + 2) * (dly + 2);
    end else begin
      exp_q.push_back({1'b1, BASE + 32'h4, 32'd2});
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({1'b0, BASE + 32'h8 + 32'(4*k), rd_mem[k]});
        exp_data[32*k +: 32] = rd_mem[k];
      end
      exp_lat = (n + 2) * (dly + 2) + LW;
    end

    ack_dly = dly;
    @(negedge clk_i);
    bus_log.delete();
    for (int i = 0; i < 50 && !cmd_ready_o; i++) @(negedge clk_i);
    check({name, "/ready"}, cmd_ready_o, 1'b1);
    cmd_valid_i  = 1'b1;
    cmd_op_i     = op;
    cmd_addr_i   = addr;
    cmd_nwords_i = nw;
    cmd_data_i   = data;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 500) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/data"}, rsp_data_o, exp_data);
    check({name, "/err"}, rsp_err_o, 1'b0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      cmd_valid_i = 1'($urandom_range(0, 1));
      cmd_op_i    = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      check({name, "/hold"}, {rsp_valid_o, cmd_ready_o, wbm_cyc_o, rsp_data_o},
            {1'b1, 1'b0, 1'b0, exp_data});
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check({name, "/handshake"}, {rsp_valid_o, cmd_ready_o}, 2'b01);
    @(posedge clk_i); #1;
    check({name, "/no_restart"}, wbm_cyc_o, 1'b0);

    check({name, "/bus_count"}, bus_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++)
      check({name, "/bus"}, bus_log[i], exp_q[i]);
    if (op) check({name, "/load_idle"}, first_rd_idle >= LW + 1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n_i      = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_op_i     = 1'b0;
    cmd_addr_i   = '0;
    cmd_nwords_i = '0;
    cmd_data_i   = '0;
    rsp_ready_i  = 1'b0;
    for (int k = 0; k < 4; k++) rd_mem[k] = 32'h0;

    #12;
    check("reset/outputs", {cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
          10'h0);
    check("reset/rsp_data", rsp_data_o, 128'h0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("reset/ready_after", cmd_ready_o, 1'b1);

    run_cmd("store1", 1'b0, 32'h5, 3'd1, {96'h0, 32'hDEAD_BEEF}, 1, 0);
    run_cmd("store4", 1'b0, 32'h30, 3'd4,
            128'h0000_00AA_3333_3333_2222_2222_1111_1111, 1, 0);
    rd_mem[0] = 32'hCAFE_F00D;
    rd_mem[1] = 32'h1234_5678;
    rd_mem[2] = 32'h5555_AAAA;
    rd_mem[3] = 32'h0BAD_0BAD;
    run_cmd("load2_bp", 1'b1, 32'h100, 3'd2, '0, 1, 10);
    run_cmd("store_n0", 1'b0, 32'h7, 3'd0, {$urandom, $urandom, $urandom, $urandom}, 2, 0);
    run_cmd("load_n7", 1'b1, 32'h8, 3'd7, '0, 1, 1);

    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 4; k++) rd_mem[k] = $urandom;
      run_cmd("random", 1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 3), $urandom_range(0, 3));
    end

    // reset during the first data write of a 4-word store
    ack_dly = 1;
    @(negedge clk_i);
    cmd_valid_i  = 1'b1;
    cmd_op_i     = 1'b0;
    cmd_addr_i   = 32'h44;
    cmd_nwords_i = 3'd4;
    cmd_data_i   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 50 && !(wbm_stb_o && wbm_adr_o == BASE + 32'h8); i++) begin
      @(posedge clk_i); #1;
    end
    check("rst_mid/reached", {wbm_stb_o, wbm_adr_o}, {1'b1, BASE + 32'h8});
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_mid/drop", {wbm_cyc_o, wbm_stb_o, cmd_ready_o, rsp_valid_o}, 4'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("rst_mid/after", {cmd_ready_o, rsp_valid_o, wbm_cyc_o}, 3'b100);
    check("rst_mid/rsp_data", rsp_data_o, 128'h0);

    rd_mem[0] = 32'h600D_D00D;
    run_cmd("post_reset_load", 1'b1, 32'h200, 3'd1, '0, 1, 0);

`ifdef CFG_LOADER_TIMEOUT_EN
    never_ack = 1'b1;
    @(negedge clk_i);
    cmd_valid_i  = 1'b1;
    cmd_op_i     = 1'b0;
    cmd_addr_i   = 32'h99;
    cmd_nwords_i = 3'd2;
    cmd_data_i   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    lat = 0;
    while (!rsp_valid_o && lat < 500) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check("timeout/latency", lat, TMO);
    check("timeout/rsp", {rsp_valid_o, rsp_err_o, wbm_stb_o, rsp_data_o}, {1'b1, 1'b1, 1'b0, 128'h0});
    never_ack = 1'b0;
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check("timeout/stb_run", last_run, TMO);
    run_cmd("after_timeout", 1'b0, 32'h1, 3'd1, {96'h0, 32'h1234}, 1, 0);
`endif

    check("gap_rule", gap_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
